// File: rtl/phy_rx.sv
// Two-lane serial receiver. Each lane finds byte alignment from a run of
// COM control bytes, then strips COM/IDL filler and buffers data bytes in a
// small deskew FIFO. Once both lanes are aligned, two bytes are taken from
// each FIFO at a time and interleaved into one 32-bit word.
module phy_rx #(
   parameter logic [7:0] COM         = 8'hBC,
   parameter logic [7:0] IDL         = 8'h7C,
   parameter int         ALIGN_COUNT = 4,
   parameter int         FIFO_DEPTH  = 4
) (
   input  logic        clk_32f,
   input  logic        reset,
   input  logic        data_in_0,
   input  logic        data_in_1,
   output logic [31:0] data_out,
   output logic        valid_out,
   output logic        active_out,
   output logic        error_out
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(ALIGN_COUNT + 1);

   typedef enum logic [1:0] {SEARCH, SYNC, ALIGNED} state_t;

   state_t          state     [2];
   state_t          state_nxt [2];
   // Last seven received bits; together with the incoming bit they form the byte.
   logic [6:0]      sr        [2];
   logic [2:0]      bcnt      [2];
   logic [2:0]      bcnt_nxt  [2];
   logic [AW-1:0]   ccnt      [2];
   logic [AW-1:0]   ccnt_nxt  [2];
   logic            din       [2];
   logic [7:0]      rx_byte   [2];
   logic            push      [2];
   logic            push_ok   [2];
   logic            drop      [2];

   logic [7:0]      mem  [2][FIFO_DEPTH];
   logic [PW-1:0]   wptr [2];
   logic [PW-1:0]   rptr [2];
   logic [CW-1:0]   cnt  [2];
   logic            pop;

   // Circular pointer advance for a FIFO whose depth need not be a power of two.
   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
      int s;
      s = int'(p) + n;
      if (s >= FIFO_DEPTH) s = s - FIFO_DEPTH;
      return PW'(s);
   endfunction

   // Per-lane alignment FSM next state, byte assembly and push decision.
   always_comb begin
      din[0] = data_in_0;
      din[1] = data_in_1;
      pop = active_out && (cnt[0] >= CW'(2)) && (cnt[1] >= CW'(2));
      for (int l = 0; l < 2; l++) begin
         rx_byte[l]   = {sr[l], din[l]};
         state_nxt[l] = state[l];
         bcnt_nxt[l]  = bcnt[l] + 3'd1;
         ccnt_nxt[l]  = ccnt[l];
         push[l]      = 1'b0;
         case (state[l])
            SEARCH: begin
               bcnt_nxt[l] = 3'd0;
               if (rx_byte[l] == COM) begin
                  ccnt_nxt[l]  = AW'(1);
                  state_nxt[l] = SYNC;
               end
            end
            SYNC: begin
               if (bcnt[l] == 3'd7) begin
                  if (rx_byte[l] == COM) begin
                     ccnt_nxt[l] = ccnt[l] + AW'(1);
                     if (ccnt[l] + AW'(1) == AW'(ALIGN_COUNT)) state_nxt[l] = ALIGNED;
                  end else begin
                     ccnt_nxt[l]  = '0;
                     state_nxt[l] = SEARCH;
                  end
               end
            end
            ALIGNED: begin
               if (bcnt[l] == 3'd7 && rx_byte[l] != COM && rx_byte[l] != IDL) push[l] = 1'b1;
            end
            default: state_nxt[l] = SEARCH;
         endcase
         // A full FIFO still accepts a byte when a pop frees room on the same edge.
         drop[l]    = push[l] && (cnt[l] == CW'(FIFO_DEPTH)) && !pop;
         push_ok[l] = push[l] && !drop[l];
      end
   end

   // Lane FSM state, shift registers and counters.
   always_ff @(posedge clk_32f) begin
      for (int l = 0; l < 2; l++) begin
         if (reset) begin
            state[l] <= SEARCH;
            sr[l]    <= '0;
            bcnt[l]  <= '0;
            ccnt[l]  <= '0;
         end else begin
            state[l] <= state_nxt[l];
            sr[l]    <= rx_byte[l][6:0];
            bcnt[l]  <= bcnt_nxt[l];
            ccnt[l]  <= ccnt_nxt[l];
         end
      end
   end

   // Deskew FIFOs: single-byte push, double-byte pop, sticky overflow flag.
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         error_out <= 1'b0;
         for (int l = 0; l < 2; l++) begin
            wptr[l] <= '0;
            rptr[l] <= '0;
            cnt[l]  <= '0;
         end
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (push_ok[l]) begin
               mem[l][wptr[l]] <= rx_byte[l];
               wptr[l]         <= ptr_add(wptr[l], 1);
            end
            if (drop[l]) error_out <= 1'b1;
            if (pop) rptr[l] <= ptr_add(rptr[l], 2);
            case ({push_ok[l], pop})
               2'b10:   cnt[l] <= cnt[l] + CW'(1);
               2'b01:   cnt[l] <= cnt[l] - CW'(2);
               2'b11:   cnt[l] <= cnt[l] - CW'(1);
               default: cnt[l] <= cnt[l];
            endcase
         end
      end
   end

   // Output word assembly, emission strobe and link-active status.
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         data_out   <= '0;
         valid_out  <= 1'b0;
         active_out <= 1'b0;
      end else begin
         active_out <= (state[0] == ALIGNED) && (state[1] == ALIGNED);
         valid_out  <= pop;
         if (pop) begin
            data_out <= {mem[0][rptr[0]], mem[1][rptr[1]],
                         mem[0][ptr_add(rptr[0], 1)], mem[1][ptr_add(rptr[1], 1)]};
         end
      end
   end

endmodule

// File: tb/tb_phy_rx.sv
// Self-checking bench for phy_rx: serial byte driver on both lanes, a word
// scoreboard drained by an output monitor, and one task per scenario.
module tb_phy_rx;

   localparam logic [7:0] COM = 8'hBC;
   localparam logic [7:0] IDL = 8'h7C;

   logic        clk_32f = 1'b0;
   logic        reset;
   logic        data_in_0;
   logic        data_in_1;
   logic [31:0] data_out;
   logic        valid_out;
   logic        active_out;
   logic        error_out;

   int          vectors        = 0;
   int          miscompares    = 0;
   int          cyc            = 0;
   int          last_bit_cyc   = 0;
   int          last_valid_cyc = -1;
   logic [31:0] exp_q [$];

   phy_rx dut (
      .clk_32f   (clk_32f),
      .reset     (reset),
      .data_in_0 (data_in_0),
      .data_in_1 (data_in_1),
      .data_out  (data_out),
      .valid_out (valid_out),
      .active_out(active_out),
      .error_out (error_out)
   );

   always #5 clk_32f = ~clk_32f;

   // Rising-edge counter used to time emissions.
   always @(posedge clk_32f) cyc <= cyc + 1;

   // Output monitor: every valid_out cycle must match the oldest expected word.
   always @(negedge clk_32f) begin
      if (valid_out === 1'b1) begin
         logic [31:0] exp_w;
         vectors++;
         last_valid_cyc = cyc;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_word: got valid_out with data_out=%h, required no word", data_out);
         end else begin
            exp_w = exp_q.pop_front();
            if (data_out !== exp_w) begin
               miscompares++;
               $display("FAIL word_data: got %h, required %h", data_out, exp_w);
            end
         end
      end
   end

   task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1);
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk_32f);
         data_in_0 = b0[i];
         data_in_1 = b1[i];
      end
      last_bit_cyc = cyc;
   endtask

   task automatic send_bits(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_32f);
         data_in_0 = 1'($urandom_range(0, 1));
         data_in_1 = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic do_reset();
      @(negedge clk_32f);
      reset     = 1'b1;
      data_in_0 = 1'b0;
      data_in_1 = 1'b0;
      @(negedge clk_32f);
      reset = 1'b0;
   endtask

   task automatic lock_both();
      for (int i = 0; i < 4; i++) send_pair(COM, COM);
      send_pair(IDL, IDL);
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      data_in_0 = 1'b0;
      data_in_1 = 1'b0;
      repeat (2) @(negedge clk_32f);
      reset = 1'b0;
      vectors += 4;
      if (data_out !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h, required 00000000", data_out); end
      if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, required 0", valid_out); end
      if (active_out !== 1'b0) begin miscompares++; $display("FAIL reset_active: got %b, required 0", active_out); end
      if (error_out !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b, required 0", error_out); end
   endtask

   task automatic test_lock();
      lock_both();
      send_pair(IDL, IDL);
      vectors += 3;
      if (active_out !== 1'b1) begin miscompares++; $display("FAIL lock_active: got %b, required 1", active_out); end
      if (valid_out !== 1'b0) begin miscompares++; $display("FAIL lock_valid: got %b, required 0", valid_out); end
      if (error_out !== 1'b0) begin miscompares++; $display("FAIL lock_error: got %b, required 0", error_out); end
   endtask

   task automatic test_word();
      int t;
      exp_q.push_back(32'h12345678);
      send_pair(8'h12, 8'h34);
      send_pair(8'h56, 8'h78);
      t = last_bit_cyc;
      send_pair(IDL, IDL);
      vectors += 2;
      if (last_valid_cyc !== t + 2) begin
         miscompares++;
         $display("FAIL word_latency: got valid at cycle %0d, required %0d", last_valid_cyc, t + 2);
      end
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL word_missing: got %0d words pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_skew();
      exp_q.push_back(32'hA1B2C3D4);
      exp_q.push_back(32'h0F1E2D3C);
      send_pair(8'hA1, IDL);
      send_pair(8'hC3, IDL);
      send_pair(8'h0F, 8'hB2);
      send_pair(8'h2D, 8'hD4);
      send_pair(IDL, 8'h1E);
      send_pair(IDL, 8'h3C);
      send_pair(IDL, IDL);
      vectors += 2;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL skew_missing: got %0d words pending, required 0", exp_q.size());
         exp_q.delete();
      end
      if (error_out !== 1'b0) begin miscompares++; $display("FAIL skew_error: got %b, required 0", error_out); end
   endtask

   task automatic test_slip();
      do_reset();
      send_bits(3);
      lock_both();
      vectors++;
      if (active_out !== 1'b1) begin miscompares++; $display("FAIL slip_active: got %b, required 1", active_out); end
      exp_q.push_back(32'hCAFEF00D);
      send_pair(8'hCA, 8'hFE);
      send_pair(8'hF0, 8'h0D);
      send_pair(IDL, IDL);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL slip_missing: got %0d words pending, required 0", exp_q.size());
         exp_q.delete();
      end
      do_reset();
      send_pair(COM, COM);
      send_pair(8'hAA, COM);
      send_pair(COM, COM);
      send_pair(COM, COM);
      send_pair(IDL, IDL);
      send_pair(IDL, IDL);
      vectors++;
      if (active_out !== 1'b0) begin miscompares++; $display("FAIL slip_nolock: got active %b, required 0", active_out); end
   endtask

   task automatic test_overflow();
      do_reset();
      lock_both();
      for (int i = 1; i <= 5; i++) send_pair(8'(i), IDL);
      send_pair(IDL, IDL);
      vectors++;
      if (error_out !== 1'b1) begin miscompares++; $display("FAIL ovf_error: got %b, required 1", error_out); end
      exp_q.push_back(32'h01E102E2);
      exp_q.push_back(32'h03E304E4);
      send_pair(IDL, 8'hE1);
      send_pair(IDL, 8'hE2);
      send_pair(IDL, 8'hE3);
      send_pair(IDL, 8'hE4);
      send_pair(IDL, 8'hE5);
      send_pair(IDL, 8'hE6);
      send_pair(IDL, IDL);
      vectors += 2;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL ovf_missing: got %0d words pending, required 0", exp_q.size());
         exp_q.delete();
      end
      if (error_out !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b, required 1", error_out); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      lock_both();
      send_pair(8'h11, 8'h22);
      send_pair(8'h33, IDL);
      do_reset();
      vectors += 4;
      if (data_out !== 32'h0) begin miscompares++; $display("FAIL mid_data: got %h, required 00000000", data_out); end
      if (valid_out !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b, required 0", valid_out); end
      if (active_out !== 1'b0) begin miscompares++; $display("FAIL mid_active: got %b, required 0", active_out); end
      if (error_out !== 1'b0) begin miscompares++; $display("FAIL mid_error: got %b, required 0", error_out); end
      send_pair(IDL, 8'h44);
      vectors++;
      if (active_out !== 1'b0) begin miscompares++; $display("FAIL mid_relock: got %b, required 0", active_out); end
      lock_both();
      exp_q.push_back(32'h55667788);
      send_pair(8'h55, 8'h66);
      send_pair(8'h77, 8'h88);
      send_pair(IDL, IDL);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL mid_missing: got %0d words pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_word();
      test_skew();
      test_slip();
      test_overflow();
      test_reset_mid();
      repeat (2) @(negedge clk_32f);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
